// File: rtl/cga_alu_pkg.sv
// cga_alu_pkg: shared Q-select / ALU-op encodings and the step sequencer state type
package cga_alu_pkg;
  localparam logic [1:0] QSEL_HOLD = 2'b00, QSEL_LOAD = 2'b01, QSEL_SHL = 2'b10, QSEL_SHR = 2'b11;
  localparam logic [1:0] ALUOP_PASS = 2'b00, ALUOP_ADD = 2'b01, ALUOP_SUB = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD, STEP, FIX, DONE} qseq_state_t;
endpackage

// File: rtl/cga_alu_qseq_if.sv
// cga_alu_qseq_if: microcode/datapath side bundle of the Q step sequencer
interface cga_alu_qseq_if #(parameter int CNT_W = 4);
  logic START;
  logic MODE;
  logic [15:0] Q_15_0;
  logic F_SIGN;
  logic [1:0] QSEL_1_0;
  logic QLI;
  logic [1:0] ALU_OP;
  logic BUSY;
  logic DONE;
  logic [CNT_W-1:0] STEP_CNT;
  modport master (output START, MODE, Q_15_0, F_SIGN, input QSEL_1_0, QLI, ALU_OP, BUSY, DONE, STEP_CNT);
  modport slave (input START, MODE, Q_15_0, F_SIGN, output QSEL_1_0, QLI, ALU_OP, BUSY, DONE, STEP_CNT);
endinterface

// File: rtl/cga_alu_qseq_cnt.sv
// cga_alu_qseq_cnt: step counter that saturates at STEPS-1 and flags the terminal count
module cga_alu_qseq_cnt #(
  parameter int STEPS = 16,
  parameter int CNT_W = 4
) (
  input  logic             ALUCLK,
  input  logic             RESET,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = cnt == CNT_W'(STEPS - 1);
  always_ff @(posedge ALUCLK) begin
    if (RESET || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cga_alu_qseq.sv
// cga_alu_qseq: Q-register step sequencer for 16-step multiply and non-restoring divide
module cga_alu_qseq
  import cga_alu_pkg::*;
#(
  parameter int STEPS = 16,
  parameter int CNT_W = 4
) (
  input logic ALUCLK,
  input logic RESET,
  cga_alu_qseq_if.slave bus
);
  qseq_state_t state, nxt;
  logic mode_q, prev_sign, tc, step;
  logic [CNT_W-1:0] cnt;
  cga_alu_qseq_cnt #(.STEPS(STEPS), .CNT_W(CNT_W)) u_cnt (
    .ALUCLK(ALUCLK),
    .RESET (RESET),
    .clr   (state == LOAD),
    .en    (step),
    .cnt   (cnt),
    .tc    (tc)
  );
  assign step = state == STEP;
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      prev_sign <= 1'b0;
    end else begin
      state     <= nxt;
      mode_q    <= (state == IDLE && bus.START) ? bus.MODE : mode_q;
      prev_sign <= state == LOAD ? 1'b0 : step ? bus.F_SIGN : prev_sign;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (bus.START ? LOAD : IDLE) :
          state == LOAD ? STEP :
          step          ? (tc ? (mode_q ? FIX : DONE) : STEP) :
          state == FIX  ? DONE : IDLE;
    bus.QSEL_1_0 = state == LOAD ? QSEL_LOAD : step ? (mode_q ? QSEL_SHL : QSEL_SHR) : QSEL_HOLD;
    bus.ALU_OP   = step ? (mode_q ? (prev_sign ? ALUOP_ADD : ALUOP_SUB) : (bus.Q_15_0[0] ? ALUOP_ADD : ALUOP_PASS)) :
                   (state == FIX && prev_sign) ? ALUOP_ADD : ALUOP_PASS;
    bus.QLI      = step && mode_q && !bus.F_SIGN;
    bus.BUSY     = state == LOAD || step || state == FIX;
    bus.DONE     = state == DONE;
    bus.STEP_CNT = step ? cnt : '0;
  end
endmodule

// File: doc/cga_alu_qseq.md
Name: cga_alu_qseq

Overview:
Q-register step sequencer for the CGA ALU. It drives the Q register select and left-shift input, and reads the Q register contents back, to run 16-step shift-add multiply and non-restoring divide sequences. It sits between the microcode start strobe and the ALU/Q datapath. Per step it chooses the ALU operation (pass/add/subtract) and generates quotient bits.

Parameters:
STEPS, 16, number of shift steps per operation (equals Q register width)
CNT_W, 4, step counter width; must satisfy 2**CNT_W >= STEPS

Ports:
ALUCLK  in  1  ALU clock, all state changes on rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  operation request; sampled only in IDLE
MODE  in  1  0 = multiply, 1 = divide; latched when START is accepted
Q_15_0  in  16  current Q register contents
F_SIGN  in  1  ALU result bit 15 of the current cycle
QSEL_1_0  out  2  Q register select: 00 hold, 01 load F, 10 shift left (QLI into LSB), 11 shift right
QLI  out  1  bit shifted into the Q LSB on a left shift
ALU_OP  out  2  00 pass, 01 add, 10 subtract
BUSY  out  1  high from LOAD through the last STEP/FIX cycle
DONE  out  1  one-cycle completion pulse
STEP_CNT  out  CNT_W  current step index during STEP, 0 otherwise

Behaviour:
- Clock and reset: one clock, ALUCLK. RESET is synchronous and active-high.
- Reset values: state IDLE, count 0, mode 0, prev_sign 0. Outputs QSEL_1_0=00, QLI=0, ALU_OP=00, BUSY=0, DONE=0, STEP_CNT=0.
- RESET has priority over everything. RESET asserted mid-operation aborts the operation: the next cycle is IDLE with no DONE pulse.
- State machine: IDLE -> LOAD -> STEP(xSTEPS) -> [FIX, divide only] -> DONE -> IDLE.
- IDLE:
  - Outputs are at their reset values.
  - START=1 at an edge latches MODE and moves to LOAD.
- LOAD (1 cycle):
  - QSEL=01, ALU_OP=00, BUSY=1.
  - Clears the counter and prev_sign.
- STEP, multiply:
  - QSEL=11.
  - ALU_OP=01 if Q_15_0[0]=1, else 00.
  - QLI=0.
- STEP, divide:
  - QSEL=10.
  - ALU_OP=01 if prev_sign=1, else 10.
  - QLI = ~F_SIGN. This is combinational from the same-cycle ALU result.
  - prev_sign <= F_SIGN at the end of the cycle.
- Counter:
  - Increments every STEP cycle.
  - At count STEPS-1, go to DONE (multiply) or FIX (divide).
  - The counter never wraps inside an operation.
- FIX (divide only, 1 cycle):
  - QSEL=00, BUSY=1.
  - ALU_OP=01 if prev_sign=1 (remainder correction), else 00.
- DONE (1 cycle):
  - DONE=1, BUSY=0, QSEL=00, ALU_OP=00.
  - Next state is IDLE unconditionally.
- Latency, with START sampled at edge 0:
  - LOAD in cycle 1, STEP in cycles 2..17.
  - Multiply: DONE in cycle 18.
  - Divide: FIX in cycle 18, DONE in cycle 19.
- START handling:
  - START is ignored outside IDLE, including during the DONE cycle.
  - START held high continuously gives back-to-back operations separated by exactly one IDLE cycle.
- MODE changes after acceptance have no effect until the next accepted START.
- All outputs are registered, except QLI and the STEP ALU_OP, which are decoded combinationally from state, Q_15_0[0], F_SIGN and prev_sign.

Decomposition:
- Shared package cga_alu_pkg holds:
  - QSEL encodings QSEL_HOLD/QSEL_LOAD/QSEL_SHL/QSEL_SHR.
  - ALU_OP encodings ALUOP_PASS/ALUOP_ADD/ALUOP_SUB.
  - The state enum qseq_state_t (IDLE, LOAD, STEP, FIX, DONE).
- One sub-module, cga_alu_qseq_cnt: the STEPS-1 terminal-count step counter with clear and enable.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: assert RESET 2 cycles during any state -> all outputs 0 and state IDLE on the next cycle; START=1 together with RESET -> stays IDLE.
- Multiply: bench Q model loaded with 0x0005, MODE=0, START at edge 0 -> QSEL=01 in cycle 1, then QSEL=11 for cycles 2..17. ALU_OP sequence is 01,00,01 followed by 00 x13. DONE=1 only in cycle 18, BUSY=1 in cycles 1..17.
- Divide: MODE=1; F_SIGN=1 in step 0, 0 in steps 1..15 -> ALU_OP is 10 at step 0, 01 at step 1, 10 at steps 2..15. QLI is 0 at step 0 and 1 at steps 1..15. QSEL=10 throughout. FIX has ALU_OP=00, DONE in cycle 19.
- Divide with a negative final remainder: F_SIGN=1 at step 15 -> FIX cycle drives ALU_OP=01, QSEL=00.
- START held high continuously with MODE=0 -> DONE in cycle 18, IDLE in 19, LOAD in 20. A START pulse in cycle 9 of an operation is ignored: no restart and STEP_CNT is unaffected.
- RESET at STEP_CNT=7 -> the next cycle shows QSEL=00, BUSY=0, STEP_CNT=0. DONE never pulses, and a new START then completes normally.
